apb3_rr_arbiter: RTL and testbench
==================================

Name: apb3_rr_arbiter

Overview:
- Shares one APB3 completer (for example the APB3 memory completer) between NumRequesters APB3 requesters.
- Arbitrates round-robin and re-issues the winner's transfer downstream with a fresh SETUP/ACCESS sequence.
- Routes the completer's response only to the winner.
- Aborts a transfer with PSLVERR on a completer timeout.
- Sits between requester-side APB3 interfaces (Renode bridge, synthetic requesters) and a single completer.

Parameters:
- NumRequesters, 2, number of upstream requester ports (2..8).
- AddressWidth, 20, APB3 address width.
- DataWidth, 32, APB3 data width.
- TimeoutCycles, 64, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  bus clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous assert, active-high.
- s_psel  in  NumRequesters  per-requester PSEL.
- s_penable  in  NumRequesters  per-requester PENABLE (ignored except for protocol checks).
- s_pwrite  in  NumRequesters  per-requester PWRITE.
- s_paddr  in  NumRequesters*AddressWidth  packed addresses; requester i occupies slice i.
- s_pwdata  in  NumRequesters*DataWidth  packed write data.
- s_prdata  out  NumRequesters*DataWidth  packed read data.
- s_pready  out  NumRequesters  per-requester PREADY.
- s_pslverr  out  NumRequesters  per-requester PSLVERR.
- m_psel, m_penable, m_pwrite  out  1  downstream control.
- m_paddr  out  AddressWidth  downstream address.
- m_pwdata  out  DataWidth  downstream write data.
- m_prdata  in  DataWidth  downstream read data.
- m_pready, m_pslverr  in  1  downstream response.
- grant_valid  out  1  a transfer is in flight.
- grant_idx  out  $clog2(NumRequesters)  index of the owning requester.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, rr_ptr = 0, timeout counter = 0.
  - All m_* outputs, s_pready, s_pslverr, s_prdata, grant_valid and grant_idx are 0.
  - An in-flight transfer is dropped with no response.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - If any s_psel is set, pick the first set bit scanning from rr_ptr upward with wrap.
  - Register winner index, paddr, pwrite and pwdata; go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: m_psel=1, m_penable=0, registered address/control/data driven; unconditionally go to ACCESS.
- ACCESS:
  - m_psel=1, m_penable=1; the counter increments each cycle.
  - When m_pready=1: in the same cycle (combinational path), s_pready[win]=1, s_prdata slice win = m_prdata, s_pslverr[win] = m_pslverr.
  - Then rr_ptr = (win+1) mod NumRequesters; go to IDLE.
- Timeout:
  - Applies when TimeoutCycles≠0 and the counter reaches TimeoutCycles-1 without m_pready.
  - Same cycle: s_pready[win]=1, s_pslverr[win]=1, s_prdata slice win = 0.
  - Next cycle m_psel=0; rr_ptr advances; go to IDLE.
  - m_pready arriving on the timeout cycle takes priority: normal completion.
- Mandatory IDLE cycle after every completion, so a requester's stale psel in its completion cycle is never re-granted.
- Minimum transfer latency, from s_psel rising while in IDLE to s_pready: 3 cycles (IDLE sample, SETUP, ACCESS with m_pready=1).
- Non-winners see s_pready=0, s_pslverr=0, s_prdata=0 at all times.
- The winner sees s_pready=0 outside its completion cycle.
- Winner deasserts s_psel mid-transfer (protocol violation): the downstream transfer still completes normally and the response pulse is still issued.
- Address/data are latched in IDLE, so later changes on the winner's s_* inputs do not affect the downstream transfer.
- grant_valid=1 in SETUP and ACCESS; grant_idx holds the winner index and reads 0 in IDLE.
- rr_ptr wraps from NumRequesters-1 to 0.
- With all requesters continuously requesting, grants rotate 0,1,…,N-1,0.

Decomposition:
- Package apb3_arb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS);
  - IdxWidth helper function, $clog2 with a minimum of 1;
  - TimeoutCntWidth constant.
- One sub-module, apb3_rr_picker: combinational round-robin picker, with inputs req[N] and ptr, and outputs valid and idx.
- The FSM, latches and response routing stay in apb3_rr_arbiter.

Test Plan:
- Single requester 0 writes 0xDEADBEEF to address 0x00010, then reads it back:
  - m_psel/m_penable follow 1/0 then 1/1;
  - s_pready[0] pulses once per transfer;
  - the read returns 0xDEADBEEF;
  - s_pready[1] stays 0.
- Requesters 0 and 1 assert s_psel in the same cycle with rr_ptr=0:
  - requester 0 is served first, requester 1 second;
  - on a repeat with both asserted, requester 0 is served again only after requester 1 (order 0,1,0,1).
- Completer holds m_pready low for 5 ACCESS cycles: s_pready[win] stays 0 until the cycle m_pready=1, and read data is forwarded in that same cycle.
- TimeoutCycles=8 with m_pready stuck low:
  - after 8 ACCESS cycles, s_pready[win]=1, s_pslverr[win]=1, prdata=0;
  - m_psel=0 on the next cycle;
  - the next requester is granted afterwards.
- rst asserted during ACCESS:
  - all outputs are 0 immediately, without waiting for a clock edge;
  - after release, the first grant goes to requester 0 (rr_ptr=0).
- m_pslverr=1 on completion with m_pready=1: forwarded to s_pslverr[win] only, and rr_ptr advances normally.

Source files
------------

// File: rtl/apb3_arb_pkg.sv
// apb3_arb_pkg: shared types and constants for the APB3 round-robin arbiter
package apb3_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam int TimeoutCntWidth = 16;

    function automatic int IdxWidth(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb3_rr_picker.sv
// apb3_rr_picker: combinational round-robin pick of the first request at or above ptr, with wrap
module apb3_rr_picker
    import apb3_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = IdxWidth(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    // scan from the farthest offset down so the nearest request to ptr is the last one written
    always_comb begin
        valid = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/apb3_rr_arbiter.sv
// apb3_rr_arbiter: round-robin sharing of one APB3 completer between several APB3 requesters
module apb3_rr_arbiter
    import apb3_arb_pkg::*;
#(
    parameter int NumRequesters = 2,
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumRequesters-1:0]             s_psel,
    input  logic [NumRequesters-1:0]             s_penable,
    input  logic [NumRequesters-1:0]             s_pwrite,
    input  logic [NumRequesters*AddressWidth-1:0] s_paddr,
    input  logic [NumRequesters*DataWidth-1:0]   s_pwdata,
    output logic [NumRequesters*DataWidth-1:0]   s_prdata,
    output logic [NumRequesters-1:0]             s_pready,
    output logic [NumRequesters-1:0]             s_pslverr,
    output logic                                 m_psel,
    output logic                                 m_penable,
    output logic                                 m_pwrite,
    output logic [AddressWidth-1:0]              m_paddr,
    output logic [DataWidth-1:0]                 m_pwdata,
    input  logic [DataWidth-1:0]                 m_prdata,
    input  logic                                 m_pready,
    input  logic                                 m_pslverr,
    output logic                                 grant_valid,
    output logic [IdxWidth(NumRequesters)-1:0]   grant_idx
);

    localparam int IW = IdxWidth(NumRequesters);
    localparam int CW = TimeoutCntWidth;

    state_t            r_state, w_next;
    logic [IW-1:0]     r_win, r_ptr, w_pick_idx;
    logic              w_pick_valid;
    logic [AddressWidth-1:0] r_addr;
    logic              r_write;
    logic [DataWidth-1:0] r_wdata;
    logic [CW-1:0]     r_cnt;
    logic              w_busy, w_acc, w_tmo, w_done;

    apb3_rr_picker #(.N(NumRequesters), .W(IW)) u_picker (
        .req   (s_psel),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_busy = (r_state != IDLE);
    assign w_acc  = (r_state == ACCESS);
    // a response on the final allowed cycle wins over the abort
    assign w_tmo  = (TimeoutCycles != 0) && (r_cnt == CW'(TimeoutCycles - 1)) && !m_pready;
    assign w_done = w_acc && (m_pready || w_tmo);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state: every completion returns to IDLE so a stale psel is never re-granted
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_pick_valid ? SETUP : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = w_done ? IDLE : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    // latch the winner's request in IDLE, count ACCESS cycles, advance the pointer past the winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win   <= '0;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_state == IDLE && w_pick_valid) begin
                r_win   <= w_pick_idx;
                r_addr  <= s_paddr[w_pick_idx*AddressWidth +: AddressWidth];
                r_write <= s_pwrite[w_pick_idx];
                r_wdata <= s_pwdata[w_pick_idx*DataWidth +: DataWidth];
            end
            r_cnt <= w_acc ? r_cnt + CW'(1) : '0;
            if (w_done) r_ptr <= (r_win == IW'(NumRequesters - 1)) ? '0 : r_win + IW'(1);
        end
    end

    // downstream drive and response routing to the winner only
    always_comb begin
        m_psel      = w_busy;
        m_penable   = w_acc;
        m_pwrite    = w_busy && r_write;
        m_paddr     = w_busy ? r_addr : '0;
        m_pwdata    = w_busy ? r_wdata : '0;
        grant_valid = w_busy;
        grant_idx   = w_busy ? r_win : '0;
        s_pready    = '0;
        s_pslverr   = '0;
        s_prdata    = '0;
        s_pready[r_win]  = w_done;
        s_pslverr[r_win] = w_done && (!m_pready || m_pslverr);
        s_prdata[r_win*DataWidth +: DataWidth] = (w_done && m_pready) ? m_prdata : '0;
    end

    // a requester must never raise PENABLE without PSEL
    a_penable_needs_psel: assert property (@(posedge clk) disable iff (rst) (s_penable & ~s_psel) == '0);

endmodule

// File: tb/tb_apb3_rr_arbiter.sv
// tb_apb3_rr_arbiter: vector table plus scoreboarded corner-case sequences for apb3_rr_arbiter
module tb_apb3_rr_arbiter;

    typedef struct {
        int          r;
        bit          wr;
        logic [19:0] a;
        logic [31:0] d;
        int          wt;
        bit          err;
        logic [31:0] er;
        bit          ee;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  s_psel = '0, s_penable = '0, s_pwrite = '0;
    logic [39:0] s_paddr = '0;
    logic [63:0] s_pwdata = '0;
    logic [63:0] s_prdata;
    logic [1:0]  s_pready, s_pslverr;
    logic        m_psel, m_penable, m_pwrite;
    logic [19:0] m_paddr;
    logic [31:0] m_pwdata, m_prdata;
    logic        m_pready, m_pslverr;
    logic        grant_valid;
    logic [0:0]  grant_idx;

    int   n_chk = 0, n_fail = 0;
    rsp_t sbq[$];
    vec_t vt[7];

    logic        stuck = 1'b0;
    logic        err_r = 1'b0;
    int          wait_n = 0;
    int          acc_cnt = 0;
    logic [31:0] mem[256];

    always #5 clk = ~clk;

    apb3_rr_arbiter #(
        .NumRequesters(2), .AddressWidth(20), .DataWidth(32), .TimeoutCycles(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    // completer model: wait_n ACCESS wait states, optional stuck-low PREADY, small memory
    always @(posedge clk) acc_cnt <= (m_psel && m_penable && !m_pready) ? acc_cnt + 1 : 0;
    always @(posedge clk) if (m_psel && m_penable && m_pready && m_pwrite) mem[m_paddr[7:0]] <= m_pwdata;
    assign m_pready  = m_psel && m_penable && !stuck && (acc_cnt == wait_n);
    assign m_prdata  = (m_psel && m_penable && m_pready && !m_pwrite) ? mem[m_paddr[7:0]] : 32'h0;
    assign m_pslverr = m_pready && err_r;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // response monitor: every PREADY pulse must match the oldest expected response
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && s_pready != 2'b00) begin
            if (sbq.size() == 0) chk("unexpected_rsp", {62'h0, s_pready}, 64'h0);
            else begin
                e = sbq.pop_front();
                chk("rsp_idx", {62'h0, s_pready}, 64'h1 << e.idx);
                chk("rsp_rdata", {32'h0, s_prdata[e.idx*32 +: 32]}, {32'h0, e.rdata});
                chk("rsp_err", {63'h0, s_pslverr[e.idx]}, {63'h0, e.err});
                chk("rsp_nonwin", {31'h0, s_prdata[(1-e.idx)*32 +: 32], s_pslverr[1-e.idx]}, 64'h0);
            end
        end
    end

    task automatic wait_rsp(output int who);
        who = -1;
        for (int k = 0; k < 40 && who < 0; k++) begin
            @(negedge clk);
            if (s_pready[0]) who = 0;
            else if (s_pready[1]) who = 1;
        end
        if (who < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_wait: no s_pready within 40 cycles, required one");
        end else begin
            @(posedge clk);
            #1 s_psel[who] = 1'b0;
        end
    endtask

    task automatic both_round(input int first);
        int w1, w2;
        sbq.push_back('{first, (first == 0) ? 32'hDEADBEEF : 32'h12345678, 1'b0});
        sbq.push_back('{1 - first, (first == 0) ? 32'h12345678 : 32'hDEADBEEF, 1'b0});
        @(posedge clk);
        #1 s_psel = 2'b11;
        wait_rsp(w1);
        chk("rr_first", w1, first);
        wait_rsp(w2);
        chk("rr_second", w2, 1 - first);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, who;
        bit done;
        vt[0] = '{0, 1'b1, 20'h00010, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0};
        vt[1] = '{0, 1'b0, 20'h00010, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0};
        vt[2] = '{1, 1'b1, 20'h00020, 32'h12345678, 2, 1'b0, 32'h0,        1'b0};
        vt[3] = '{1, 1'b0, 20'h00020, 32'h0,        5, 1'b0, 32'h12345678, 1'b0};
        vt[4] = '{1, 1'b1, 20'h00030, 32'hA5A5A5A5, 1, 1'b0, 32'h0,        1'b0};
        vt[5] = '{0, 1'b0, 20'h00030, 32'h0,        3, 1'b0, 32'hA5A5A5A5, 1'b0};
        vt[6] = '{0, 1'b0, 20'h00010, 32'h0,        0, 1'b1, 32'hDEADBEEF, 1'b1};

        @(negedge clk);
        chk("reset_ctl", {m_psel, m_penable, m_pwrite, grant_valid, grant_idx, s_pready, s_pslverr}, 64'h0);
        chk("reset_data", {m_paddr, m_pwdata}, 64'h0);
        chk("reset_prdata", s_prdata, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            wait_n = vt[i].wt;
            err_r = vt[i].err;
            s_pwrite[vt[i].r] = vt[i].wr;
            s_paddr[vt[i].r*20 +: 20] = vt[i].a;
            s_pwdata[vt[i].r*32 +: 32] = vt[i].d;
            sbq.push_back('{vt[i].r, vt[i].er, vt[i].ee});
            s_psel[vt[i].r] = 1'b1;
            n = 0;
            done = 1'b0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
                if (n == 2) begin
                    chk("setup_ctl", {m_psel, m_penable, grant_valid}, 3'b101);
                    chk("setup_idx", grant_idx, vt[i].r);
                    chk("setup_addr", m_paddr, vt[i].a);
                    s_paddr[vt[i].r*20 +: 20] = ~vt[i].a;
                end
                if (n == 3) begin
                    chk("access_ctl", {m_psel, m_penable, m_pwrite}, {2'b11, vt[i].wr});
                    chk("access_addr_latched", m_paddr, vt[i].a);
                end
                if (s_pready[vt[i].r]) done = 1'b1;
            end
            chk("latency", n, 3 + vt[i].wt);
            @(posedge clk);
            #1 s_psel[vt[i].r] = 1'b0;
        end
        wait_n = 0;
        err_r = 1'b0;

        s_pwrite = 2'b00;
        s_paddr = {20'h00020, 20'h00010};
        both_round(1);

        stuck = 1'b1;
        s_pwrite[1] = 1'b1;
        s_paddr[39:20] = 20'h00040;
        s_pwdata[63:32] = 32'hCAFEF00D;
        @(posedge clk);
        #1 s_psel[1] = 1'b1;
        n = 0;
        while (!m_penable && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_access", m_penable, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ctl", {m_psel, m_penable, m_pwrite, grant_valid, grant_idx, s_pready, s_pslverr}, 64'h0);
        chk("rst_async_data", {m_paddr, m_pwdata}, 64'h0);
        chk("rst_async_prdata", s_prdata, 64'h0);
        s_psel = 2'b00;
        s_pwrite = 2'b00;
        s_paddr = {20'h00020, 20'h00010};
        stuck = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        both_round(0);
        both_round(0);

        stuck = 1'b1;
        sbq.push_back('{0, 32'h0, 1'b1});
        sbq.push_back('{1, 32'h12345678, 1'b0});
        @(posedge clk);
        #1 s_psel = 2'b11;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (m_penable) n++;
            if (s_pready != 2'b00) done = 1'b1;
        end
        chk("tmo_access_cycles", n, 8);
        chk("tmo_winner", {62'h0, s_pready}, 64'h1);
        @(posedge clk);
        #1 s_psel[0] = 1'b0;
        @(negedge clk);
        chk("tmo_idle", {m_psel, grant_valid}, 2'b00);
        @(negedge clk);
        chk("tmo_next_grant", {grant_valid, grant_idx}, 2'b11);
        stuck = 1'b0;
        wait_rsp(who);
        chk("tmo_next_who", who, 1);

        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
